// File: rtl/ara_pkg.sv
// Shared types for the inter-cluster ring slide sequencer.
package ara_pkg;

    typedef enum logic {
        RING_LEFT  = 1'b0,
        RING_RIGHT = 1'b1
    } ring_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } ring_ctrl_state_e;

    // Index width for n items; a single item still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    localparam int unsigned RingNrClusters = 4;
    localparam int unsigned RingHopWidth   = idx_width(RingNrClusters);
    localparam int unsigned RingBeatWidth  = 16;

    typedef struct packed {
        ring_dir_e                dir;
        logic [RingHopWidth-1:0]  hops;
        logic [RingBeatWidth-1:0] beats;
    } ring_slide_cmd_t;

endpackage

// File: rtl/ring_slide_ctrl_if.sv
// Command, router-configuration and observed-handshake signals between the
// slide unit / ring router (master side) and the slide sequencer (slave side).
interface ring_slide_ctrl_if
    import ara_pkg::*;
#(
    parameter int unsigned HopWidth     = idx_width(RingNrClusters),
    parameter int unsigned BeatCntWidth = RingBeatWidth
);
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic                    cmd_dir_i;
    logic [HopWidth-1:0]     cmd_hops_i;
    logic [BeatCntWidth-1:0] cmd_beats_i;
    logic                    abort_i;

    logic                    dir_o;
    logic                    bypass_o;
    logic                    conf_valid_o;
    logic                    run_o;

    logic                    tx_valid_i;
    logic                    tx_ready_i;
    logic                    rx_valid_i;
    logic                    rx_ready_i;

    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;

    modport master (
        output cmd_valid_i, cmd_dir_i, cmd_hops_i, cmd_beats_i, abort_i,
        output tx_valid_i, tx_ready_i, rx_valid_i, rx_ready_i,
        input  cmd_ready_o, dir_o, bypass_o, conf_valid_o, run_o,
        input  busy_o, done_o, err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_dir_i, cmd_hops_i, cmd_beats_i, abort_i,
        input  tx_valid_i, tx_ready_i, rx_valid_i, rx_ready_i,
        output cmd_ready_o, dir_o, bypass_o, conf_valid_o, run_o,
        output busy_o, done_o, err_o
    );

endinterface

// File: rtl/ring_beat_counter.sv
// Saturating beat counter. reached looks one step ahead (count after this
// cycle's enable equals the limit) so the sequencer can leave RUN on the
// same edge as the final beat. overflow flags an enable while saturated.
module ring_beat_counter
    import ara_pkg::*;
#(
    parameter int unsigned Width = RingBeatWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             en,
    input  logic [Width-1:0] limit,
    output logic             reached,
    output logic             overflow
);

    localparam logic [Width-1:0] One = Width'(1);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;
    logic             saturated;

    assign saturated = (count_q == limit);

    // Clear has priority; a saturated counter holds its value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !saturated) begin
            count_d = count_q + One;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign reached  = (count_d == limit);
    assign overflow = en && saturated && !clr;

endmodule

// File: rtl/ring_slide_ctrl.sv
// Per-cluster ring slide sequencer: takes one slide command, programs the
// router direction/bypass, opens the ring and counts tx/rx beats until both
// directions have moved the requested number of beats.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a command; cmd_ready_o high
//   ST_CONFIG | router config strobe out, dir/bypass already stable
//   ST_RUN    | ring open (run_o), tx/rx beats counted
//   ST_DONE   | one-cycle completion pulse, then back to idle
module ring_slide_ctrl
    import ara_pkg::*;
#(
    parameter int unsigned NrClusters   = 4,
    parameter int unsigned BeatCntWidth = 16,
    parameter int unsigned HopWidth     = idx_width(NrClusters)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [HopWidth-1:0] cluster_id_i,
    ring_slide_ctrl_if.slave    bus
);

    // One extra bit so NrClusters itself is representable for the range checks.
    localparam logic [HopWidth:0] HopLimit = (HopWidth + 1)'(NrClusters);

    ring_ctrl_state_e        state_q, state_d;
    ring_dir_e               dir_q, dir_d;
    logic                    bypass_q, bypass_d;
    logic                    conf_q, conf_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [BeatCntWidth-1:0] beats_q, beats_d;

    logic tx_hs, rx_hs;
    logic in_run;
    logic cnt_clr;
    logic tx_reached, rx_reached;
    logic tx_ovf, rx_ovf;
    logic stray_hs;
    logic hop_err, id_err;

    assign tx_hs    = bus.tx_valid_i && bus.tx_ready_i;
    assign rx_hs    = bus.rx_valid_i && bus.rx_ready_i;
    assign in_run   = (state_q == ST_RUN);
    assign stray_hs = !in_run && (tx_hs || rx_hs);
    assign hop_err  = ({1'b0, bus.cmd_hops_i} >= HopLimit);
    assign id_err   = ({1'b0, cluster_id_i} >= HopLimit);

    ring_beat_counter #(.Width(BeatCntWidth)) u_tx_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (cnt_clr),
        .en       (in_run && tx_hs),
        .limit    (beats_q),
        .reached  (tx_reached),
        .overflow (tx_ovf)
    );

    ring_beat_counter #(.Width(BeatCntWidth)) u_rx_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (cnt_clr),
        .en       (in_run && rx_hs),
        .limit    (beats_q),
        .reached  (rx_reached),
        .overflow (rx_ovf)
    );

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        bypass_d = bypass_q;
        conf_d   = 1'b0;
        done_d   = 1'b0;
        beats_d  = beats_q;
        cnt_clr  = 1'b0;
        err_d    = err_q || stray_hs || tx_ovf || rx_ovf;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    dir_d    = ring_dir_e'(bus.cmd_dir_i);
                    bypass_d = (bus.cmd_hops_i == '0);
                    beats_d  = bus.cmd_beats_i;
                    cnt_clr  = 1'b1;
                    conf_d   = 1'b1;
                    // A new command starts with a clean error flag, but faults
                    // seen on the accept edge itself still belong to it.
                    err_d    = stray_hs || hop_err || id_err;
                    state_d  = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                if (bus.abort_i) begin
                    conf_d   = 1'b1;
                    bypass_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (bypass_q || (beats_q == '0)) begin
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort_i) begin
                    // Hand the router back in pass-through before going idle.
                    conf_d   = 1'b1;
                    bypass_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (tx_reached && rx_reached) begin
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            dir_q    <= RING_LEFT;
            bypass_q <= 1'b1;
            conf_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            beats_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            bypass_q <= bypass_d;
            conf_q   <= conf_d;
            done_q   <= done_d;
            err_q    <= err_d;
            beats_q  <= beats_d;
        end
    end

    assign bus.cmd_ready_o  = (state_q == ST_IDLE);
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.run_o        = in_run;
    assign bus.dir_o        = dir_q;
    assign bus.bypass_o     = bypass_q;
    assign bus.conf_valid_o = conf_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_ring_slide_ctrl.sv
// Bench for ring_slide_ctrl: a vector table of slide commands checked through
// a scoreboard on conf_valid_o/done_o, plus hand-written corner sequences.
module tb_ring_slide_ctrl;
    import ara_pkg::*;

    localparam int unsigned NrClusters = 4;
    localparam int unsigned BeatW      = 16;
    localparam int unsigned HopW       = idx_width(NrClusters);
    localparam int          NumVec     = 7;

    typedef struct {
        ring_slide_cmd_t cmd;
        int              rx_delay;
        logic            exp_bypass;
        int              exp_lat;
        logic            exp_err;
    } vec_t;

    typedef struct {
        int   dir;
        int   bypass;
        int   t0;
        int   lat;
        int   err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [HopW-1:0] cluster_id = '0;

    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    vec_t vec[NumVec];

    ring_slide_ctrl_if #(.HopWidth(HopW), .BeatCntWidth(BeatW)) bus ();

    ring_slide_ctrl #(.NrClusters(NrClusters), .BeatCntWidth(BeatW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cluster_id_i (cluster_id),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int dir, input int hops, input int beats,
                                input int rxd, input int byp, input int lat, input int err);
        vec_t v;
        v.cmd.dir   = ring_dir_e'(dir[0]);
        v.cmd.hops  = hops[HopW-1:0];
        v.cmd.beats = beats[BeatW-1:0];
        v.rx_delay  = rxd;
        v.exp_bypass = byp[0];
        v.exp_lat   = lat;
        v.exp_err   = err[0];
        return v;
    endfunction

    task automatic set_hs(input logic tx, input logic rx);
        bus.tx_valid_i = tx;
        bus.rx_ready_i = rx;
    endtask

    // Waits for cmd_ready_o, presents one command for one edge; t0 is chosen
    // so that cycle (cyc - t0) == 1 is the CONFIG cycle.
    task automatic accept(input logic dir, input int hops, input int beats, output int t0);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", int'(bus.cmd_ready_o), 1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_dir_i   = dir;
        bus.cmd_hops_i  = hops[HopW-1:0];
        bus.cmd_beats_i = beats[BeatW-1:0];
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        bus.cmd_valid_i = 1'b0;
    endtask

    // Scoreboard side: config strobe and completion pulse against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.conf_valid_o) begin
                if (sb.size() == 0) begin
                    check("conf_unexpected_sb_size", sb.size(), 1);
                end else begin
                    check("conf_cycle", cyc - sb[0].t0, 1);
                    check("conf_dir", int'(bus.dir_o), sb[0].dir);
                    check("conf_bypass", int'(bus.bypass_o), sb[0].bypass);
                end
            end
            if (bus.done_o) begin
                if (sb.size() == 0) begin
                    check("done_unexpected_sb_size", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc - e.t0, e.lat);
                    check("done_err", int'(bus.err_o), e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int c;

        bus.cmd_valid_i = 1'b0;
        bus.cmd_dir_i   = 1'b0;
        bus.cmd_hops_i  = '0;
        bus.cmd_beats_i = '0;
        bus.abort_i     = 1'b0;
        bus.tx_valid_i  = 1'b0;
        bus.tx_ready_i  = 1'b1;
        bus.rx_valid_i  = 1'b1;
        bus.rx_ready_i  = 1'b0;

        //      dir hops beats rxd  byp lat err
        vec[0] = mk(1, 1, 4, 0, 0, 6,  0);
        vec[1] = mk(0, 0, 8, 0, 1, 2,  0);
        vec[2] = mk(0, 2, 3, 8, 0, 13, 0);
        vec[3] = mk(1, 3, 0, 0, 0, 2,  0);
        vec[4] = mk(0, 1, 1, 0, 0, 3,  0);
        vec[5] = mk(1, 2, 5, 2, 0, 9,  0);
        vec[6] = mk(1, 0, 0, 0, 1, 2,  0);

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dir", int'(bus.dir_o), 0);
        check("rst_bypass", int'(bus.bypass_o), 1);
        check("rst_conf", int'(bus.conf_valid_o), 0);
        check("rst_run", int'(bus.run_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_err", int'(bus.err_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_ready", int'(bus.cmd_ready_o), 1);
        rst = 1'b0;

        // Table-driven commands.
        mon_en = 1'b1;
        for (int i = 0; i < NumVec; i++) begin
            int   vt0;
            int   vc;
            int   nb;
            logic active;
            logic tx;
            logic rx;
            accept(vec[i].cmd.dir, int'(vec[i].cmd.hops), int'(vec[i].cmd.beats), vt0);
            sb.push_back('{dir: int'(vec[i].cmd.dir), bypass: int'(vec[i].exp_bypass),
                           t0: vt0, lat: vec[i].exp_lat, err: int'(vec[i].exp_err)});
            nb     = int'(vec[i].cmd.beats);
            active = !vec[i].exp_bypass && (nb != 0);
            for (int k = 1; k <= vec[i].exp_lat + 1; k++) begin
                @(negedge clk);
                vc = cyc - vt0;
                tx = active && (vc >= 2) && (vc < 2 + nb);
                rx = active && (vc >= 2 + vec[i].rx_delay) && (vc < 2 + vec[i].rx_delay + nb);
                set_hs(tx, rx);
                check("vec_run", int'(bus.run_o), int'(active && (vc >= 2) && (vc < vec[i].exp_lat)));
                check("vec_busy", int'(bus.busy_o), int'(vc <= vec[i].exp_lat));
            end
            check("vec_ready_after_done", int'(bus.cmd_ready_o), 1);
        end
        mon_en = 1'b0;
        check("sb_empty", sb.size(), 0);

        // Abort during RUN.
        accept(1'b1, 1, 10, t0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            c = cyc - t0;
            set_hs(c >= 2 && c <= 3, c >= 2 && c <= 3);
            bus.abort_i = (c == 3);
            if (c == 3) check("abort_run_before", int'(bus.run_o), 1);
            if (c == 4) begin
                check("abort_run_low", int'(bus.run_o), 0);
                check("abort_conf", int'(bus.conf_valid_o), 1);
                check("abort_bypass", int'(bus.bypass_o), 1);
            end
            if (c == 5) begin
                check("abort_ready", int'(bus.cmd_ready_o), 1);
                check("abort_conf_once", int'(bus.conf_valid_o), 0);
                check("abort_err", int'(bus.err_o), 0);
            end
            check("abort_no_done", int'(bus.done_o), 0);
        end

        // Fourth tx beat on a 3-beat command while rx is still pending.
        accept(1'b1, 1, 3, t0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            c = cyc - t0;
            set_hs(c >= 2 && c <= 5, c >= 7 && c <= 9);
            if (c == 6) begin
                check("ovf_err_set", int'(bus.err_o), 1);
                check("ovf_run", int'(bus.run_o), 1);
                check("ovf_tx_cnt", int'(dut.u_tx_cnt.count_q), 3);
            end
            if (c == 9) check("ovf_err_sticky", int'(bus.err_o), 1);
            check("ovf_done", int'(bus.done_o), int'(c == 10));
            if (c == 10) check("ovf_err_at_done", int'(bus.err_o), 1);
            if (c == 11) check("ovf_err_after_done", int'(bus.err_o), 1);
        end
        accept(1'b0, 0, 0, t0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            c = cyc - t0;
            if (c == 1) check("err_clear_on_accept", int'(bus.err_o), 0);
            check("bypass_done", int'(bus.done_o), int'(c == 2));
        end

        // Reset mid-RUN.
        accept(1'b1, 2, 6, t0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            c = cyc - t0;
            set_hs(c >= 2 && c <= 3, c >= 2 && c <= 3);
            rst = (c == 3);
            if (c == 4) begin
                check("mid_rst_run", int'(bus.run_o), 0);
                check("mid_rst_bypass", int'(bus.bypass_o), 1);
                check("mid_rst_dir", int'(bus.dir_o), 0);
                check("mid_rst_conf", int'(bus.conf_valid_o), 0);
                check("mid_rst_busy", int'(bus.busy_o), 0);
                check("mid_rst_ready", int'(bus.cmd_ready_o), 1);
                check("mid_rst_err", int'(bus.err_o), 0);
            end
            check("mid_rst_no_done", int'(bus.done_o), 0);
        end

        // Handshake while idle flags an error; the next accept clears it.
        @(negedge clk);
        set_hs(1'b0, 1'b1);
        @(negedge clk);
        set_hs(1'b0, 1'b0);
        check("idle_hs_err", int'(bus.err_o), 1);
        check("idle_hs_busy", int'(bus.busy_o), 0);
        accept(1'b0, 0, 0, t0);
        @(negedge clk);
        check("idle_hs_err_cleared", int'(bus.err_o), 0);
        @(negedge clk);
        check("idle_hs_done", int'(bus.done_o), 1);

        // abort_i together with cmd_valid_i in IDLE: command is accepted.
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.abort_i     = 1'b1;
        bus.cmd_dir_i   = 1'b0;
        bus.cmd_hops_i  = HopW'(1);
        bus.cmd_beats_i = BeatW'(2);
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        bus.cmd_valid_i = 1'b0;
        bus.abort_i     = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            c = cyc - t0;
            set_hs(c >= 2 && c <= 3, c >= 2 && c <= 3);
            if (c == 1) begin
                check("abort_idle_conf", int'(bus.conf_valid_o), 1);
                check("abort_idle_bypass", int'(bus.bypass_o), 0);
            end
            if (c == 2) check("abort_idle_run", int'(bus.run_o), 1);
            check("abort_idle_done", int'(bus.done_o), int'(c == 4));
            if (c == 5) check("abort_idle_ready", int'(bus.cmd_ready_o), 1);
        end

        // Command held valid across a DONE cycle waits one cycle.
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_dir_i   = 1'b0;
        bus.cmd_hops_i  = '0;
        bus.cmd_beats_i = '0;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            c = cyc - t0;
            check("back2back_conf", int'(bus.conf_valid_o), int'(c == 1 || c == 4));
            check("back2back_done", int'(bus.done_o), int'(c == 2 || c == 5));
            check("back2back_ready", int'(bus.cmd_ready_o), int'(c == 3 || c == 6));
            if (c == 4) bus.cmd_valid_i = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_slide_ctrl.md
Name: ring_slide_ctrl

Overview:
- Per-cluster sequencer for the inter-cluster ring router. It accepts one cross-cluster slide command at a time from the slide unit.
- It programs the router's direction and bypass configuration, then opens the ring for transfer and counts transmit and receive beats.
- It pulses done when all expected beats have crossed in both directions.
- It sits between the slide unit and the ring router inside each cluster macro.

Parameters:
NrClusters, 4, number of ring clusters; must be >= 2
BeatCntWidth, 16, width of the beat counters and of cmd_beats_i
HopWidth, idx_width(NrClusters), width of cmd_hops_i

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
cluster_id_i  in  HopWidth  static cluster index, used only by err checks
cmd_valid_i  in  1  slide command valid
cmd_ready_o  out  1  high only in IDLE
cmd_dir_i  in  1  0 = slidedown (left), 1 = slideup (right)
cmd_hops_i  in  HopWidth  cluster distance; 0 = local slide, ring bypassed
cmd_beats_i  in  BeatCntWidth  beats to send and to receive
abort_i  in  1  flush; returns the block to IDLE
dir_o  out  1  router direction
bypass_o  out  1  router bypass
conf_valid_o  out  1  one-cycle router configuration strobe
run_o  out  1  ring open; the slide unit may handshake only while run_o is high
tx_valid_i, tx_ready_i  in  1 each  observed handshake, slide unit to router
rx_valid_i, rx_ready_i  in  1 each  observed handshake, router to slide unit
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i high at a clock edge) values:
  - state = IDLE
  - dir_o = 0, bypass_o = 1
  - conf_valid_o, run_o, done_o, err_o, busy_o = 0
  - counters = 0
- Reset wins over every other input, including mid-RUN. No done_o is produced for an interrupted command.
- States are IDLE, CONFIG, RUN, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, at edge T:
    - latch dir_o = cmd_dir_i;
    - latch bypass_o = (cmd_hops_i == 0);
    - latch beats;
    - clear both counters and err_o;
    - go to CONFIG.
- CONFIG (cycle T+1):
  - conf_valid_o = 1 for exactly this cycle; dir_o and bypass_o are already stable.
  - If bypass_o = 1 or beats == 0, next state is DONE. Otherwise next state is RUN.
- RUN (first cycle T+2):
  - run_o = 1.
  - tx_cnt increments on tx_valid_i & tx_ready_i.
  - rx_cnt increments on rx_valid_i & rx_ready_i.
  - Both counters may increment in the same cycle.
  - Each counter saturates at beats. A handshake on a saturated counter sets err_o and does not change the count.
  - Leave for DONE on the edge where both counters equal beats, counting that cycle's handshakes. run_o is low in DONE.
- DONE:
  - done_o = 1 for one cycle, then IDLE; cmd_ready_o returns to 1 one cycle after done_o.
  - Minimum command-to-done latency is 2 cycles (bypass or zero beats).
  - With no stalls, done_o is asserted at T+2+beats.
- Handshakes outside RUN:
  - A tx or rx handshake in any state other than RUN sets err_o; counters do not change.
  - Exception: a handshake in the RUN exit cycle counts normally.
- Hop limit: cmd_hops_i >= NrClusters sets err_o on accept. The command still executes, with bypass = 0.
- abort_i:
  - From CONFIG or RUN: go to IDLE next cycle; run_o drops immediately (registered, next edge).
  - The abort also issues one conf_valid_o pulse with bypass_o = 1, restoring the router to pass-through.
  - No done_o is produced.
  - abort_i in IDLE or DONE is ignored; a DONE pulse still completes.
  - abort_i together with cmd_valid_i in IDLE: the command is accepted.
- Simultaneous done and new command: the new command cannot be accepted in the DONE cycle; it waits one cycle.
- All outputs are registered except cmd_ready_o, busy_o and run_o, which decode directly from the state register.

Decomposition:
- ara_pkg holds:
  - ring_dir_e (RING_LEFT = 0, RING_RIGHT = 1);
  - ring_slide_cmd_t {dir, hops, beats};
  - the ring_ctrl_state_e enum.
- One sub-module, ring_beat_counter, is instantiated twice (tx and rx). It provides a saturating counter with clear, enable, limit, reached and overflow outputs.

Test Plan:
- Slideup, hops = 1, beats = 4, tx and rx one per cycle from T+2 -> conf_valid_o at T+1 with dir_o = 1, bypass_o = 0; run_o high during T+2..T+5; done_o at T+6; err_o = 0.
- Local slide, hops = 0, beats = 8 -> conf_valid_o at T+1 with bypass_o = 1; run_o never high; done_o at T+2.
- beats = 3, tx bursts 3 back-to-back, rx stalls then arrives at T+10 -> done_o at T+13; run_o stays high until rx_cnt = 3.
- Abort at T+3 with beats = 10 -> run_o low from T+4; conf_valid_o at T+4 with bypass_o = 1; no done_o; cmd_ready_o high at T+5.
- Fourth tx handshake with beats = 3 while rx is still pending -> err_o = 1 and stays set; tx_cnt stays 3; err_o clears on the next command accept.
- rst_i asserted mid-RUN -> next cycle all outputs at reset values, bypass_o = 1, no done_o.
